// File: rtl/noise_histogram.sv
// noise_histogram: popcount histogram, popcount sum and stuck-bit
// monitor for the 16-bit LFSR noise DAC bus.
module noise_histogram #(
   parameter int WINDOW_LOG2 = 16,
   parameter int CNT_W       = WINDOW_LOG2 + 1
) (
   input  logic                   sclk,
   input  logic                   rst_n,
   input  logic [15:0]            dac,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   input  logic                   rd_en,
   input  logic [4:0]             rd_addr,
   output logic [CNT_W-1:0]       rd_data,
   output logic                   rd_valid,
   output logic [WINDOW_LOG2+4:0] pc_sum,
   output logic [15:0]            stuck
);

   localparam int SW = WINDOW_LOG2 + 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACQ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                 state;
   state_t                 state_nx;
   logic [WINDOW_LOG2-1:0] cnt;
   logic                   drn;
   logic                   fin;
   logic                   v1;
   logic                   v2;
   logic [15:0]            dac_q;
   logic [15:0]            and_acc;
   logic [15:0]            or_acc;
   logic [4:0]             pc2;
   logic [CNT_W-1:0]       bin [17];

   // fin marks the second DRAIN cycle, i.e. the edge entering DONE
   assign fin  = (state == S_DRAIN) && drn;
   assign busy = state inside {S_CLEAR, S_ACQ, S_DRAIN};

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE, S_DONE: if (start) state_nx = S_CLEAR;
         S_CLEAR:        state_nx = S_ACQ;
         S_ACQ:          if (&cnt) state_nx = S_DRAIN;
         S_DRAIN:        if (drn) state_nx = S_DONE;
         default:        state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         drn     <= 1'b0;
         done    <= 1'b0;
         v1      <= 1'b0;
         v2      <= 1'b0;
         dac_q   <= '0;
         pc2     <= '0;
         and_acc <= '0;
         or_acc  <= '0;
         stuck   <= '0;
      end else begin
         drn   <= (state == S_DRAIN) ? ~drn : 1'b0;
         done  <= fin;
         v1    <= (state == S_ACQ);
         dac_q <= dac;
         v2    <= v1;
         pc2   <= 5'($countones(dac_q));
         if (state == S_CLEAR) cnt <= '0;
         else if (state == S_ACQ) cnt <= cnt + 1'b1;
         if (state == S_CLEAR) begin
            and_acc <= 16'hFFFF;
            or_acc  <= '0;
            stuck   <= '0;
         end else begin
            if (v1) begin
               and_acc <= and_acc & dac_q;
               or_acc  <= or_acc | dac_q;
            end
            if (fin) stuck <= and_acc | ~or_acc;
         end
      end
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         pc_sum <= '0;
         for (int i = 0; i < 17; i++) bin[i] <= '0;
      end else if (state == S_CLEAR) begin
         pc_sum <= '0;
         for (int i = 0; i < 17; i++) bin[i] <= '0;
      end else if (v2) begin
         pc_sum <= pc_sum + SW'(pc2);
         for (int i = 0; i < 17; i++)
            if (pc2 == 5'(i)) bin[i] <= bin[i] + 1'b1;
      end
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en)
            rd_data <= (rd_addr <= 5'd16) ? bin[rd_addr] : '0;
      end
   end

endmodule

// File: tb/tb_noise_histogram.sv
// tb_noise_histogram: random and directed windows against a
// timeline-level histogram model, checked every cycle.
module tb_noise_histogram;

   localparam int WL = 4;
   localparam int W  = 1 << WL;
   localparam int CW = WL + 1;
   localparam int SW = WL + 5;

   logic          sclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          rd_en = 1'b0;
   logic [15:0]   dac = '0;
   logic [4:0]    rd_addr = '0;
   logic          busy;
   logic          done;
   logic          rd_valid;
   logic [CW-1:0] rd_data;
   logic [SW-1:0] pc_sum;
   logic [15:0]   stuck;

   int errors = 0;
   int checks = 0;

   noise_histogram #(.WINDOW_LOG2(WL)) dut (
      .sclk    (sclk),
      .rst_n   (rst_n),
      .dac     (dac),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .rd_valid(rd_valid),
      .pc_sum  (pc_sum),
      .stuck   (stuck)
   );

   always #5 sclk = ~sclk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // model: timeline relative to the accepted start edge
   typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
   mph_t        ph = M_IDLE;
   longint      cyc = 0;
   longint      t0 = 0;
   int          rel;
   logic [15:0] samp [W];
   int          hist [17];
   logic        e_busy = 0;
   logic        e_done = 0;
   logic        e_rv = 0;
   int          e_rd = 0;
   bit          chk_rd = 1;
   int          e_pc = 0;
   logic [15:0] e_stuck = '0;
   bit          armed = 0;
   bit          st;

   always @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         ph = M_IDLE;
         e_busy = 0;
         e_done = 0;
         e_rv = 0;
         e_rd = 0;
         chk_rd = 1;
         e_pc = 0;
         e_stuck = '0;
         foreach (hist[i]) hist[i] = 0;
      end else begin
         cyc++;
         e_rv = rd_en;
         if (rd_en) begin
            chk_rd = (ph != M_RUN) || (rd_addr > 16);
            e_rd = (rd_addr > 16) ? 0 : hist[rd_addr];
         end
         e_done = 0;
         if (ph != M_RUN) begin
            if (start) begin
               ph = M_RUN;
               t0 = cyc;
            end
         end else begin
            rel = int'(cyc - t0);
            if (rel == 1) begin
               e_pc = 0;
               e_stuck = '0;
            end
            if (rel >= 2 && rel <= W + 1) samp[rel-2] = dac;
            if (rel >= 4 && rel <= W + 3) e_pc += $countones(samp[rel-4]);
            if (rel == W + 3) begin
               foreach (hist[i]) hist[i] = 0;
               for (int k = 0; k < W; k++) hist[$countones(samp[k])]++;
               for (int i = 0; i < 16; i++) begin
                  st = 1;
                  for (int k = 1; k < W; k++)
                     if (samp[k][i] !== samp[0][i]) st = 0;
                  e_stuck[i] = st;
               end
               ph = M_DONE;
               e_done = 1;
            end
         end
         e_busy = (ph == M_RUN);
      end
   end

   always @(negedge sclk) begin
      if (armed) begin
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("rd_valid", rd_valid, e_rv);
         if (chk_rd) chk("rd_data", rd_data, e_rd);
         chk("pc_sum", pc_sum, e_pc);
         chk("stuck", stuck, e_stuck);
      end
   end

   function automatic logic [15:0] pat(input int mode, input int k,
                                       input logic [15:0] msk,
                                       input logic [15:0] frc);
      logic [15:0] one;
      one = 16'd1;
      case (mode)
         0:       pat = 16'h0000;
         1:       pat = 16'hFFFF;
         2:       pat = (one << k) - 16'd1;
         default: pat = (16'($urandom) & msk) | frc;
      endcase
   endfunction

   // called just after an edge; start is sampled at the next edge (t)
   task automatic run(input int mode, input bit extra, output int lat);
      logic [15:0] msk;
      logic [15:0] frc;
      msk = 16'($urandom) | 16'($urandom) | 16'($urandom);
      frc = 16'($urandom) & ~msk;
      start = 1;
      @(posedge sclk);
      #1 start = 0;
      lat = -1;
      for (int n = 1; n <= W + 10; n++) begin
         if (n >= 2 && n <= W + 1) dac = pat(mode, n - 2, msk, frc);
         else dac = 16'($urandom);
         start = extra && (n == 5 || n == W + 2 || n == W + 3);
         if (mode == 3 && $urandom_range(0, 3) == 0) begin
            rd_en = 1;
            rd_addr = 5'($urandom_range(0, 20));
         end else rd_en = 0;
         @(posedge sclk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      start = 0;
      rd_en = 0;
      chk("latency", lat, W + 3);
   endtask

   task automatic rd(input int a, output logic [CW-1:0] d, output logic v);
      rd_en = 1;
      rd_addr = 5'(a);
      @(posedge sclk);
      #1 d = rd_data;
      v = rd_valid;
      rd_en = 0;
   endtask

   task automatic bin_total(output int tot);
      logic [CW-1:0] d;
      logic          v;
      tot = 0;
      for (int a = 0; a < 17; a++) begin
         rd(a, d, v);
         tot += int'(d);
      end
   endtask

   initial begin
      int            lat;
      int            tot;
      logic [CW-1:0] d;
      logic          v;
      @(posedge sclk);
      #1 armed = 1;
      chk("rst_busy", busy, 0);
      chk("rst_pc_sum", pc_sum, 0);
      @(posedge sclk);
      #1 rst_n = 1;
      @(posedge sclk);
      #1;

      run(0, 0, lat);
      rd(0, d, v);
      chk("zeros_bin0", d, 16);
      bin_total(tot);
      chk("zeros_total", tot, 16);
      chk("zeros_pc_sum", pc_sum, 0);
      chk("zeros_stuck", stuck, 16'hFFFF);

      run(1, 0, lat);
      rd(16, d, v);
      chk("ones_bin16", d, 16);
      chk("ones_pc_sum", pc_sum, 256);
      chk("ones_stuck", stuck, 16'hFFFF);

      run(2, 0, lat);
      rd(7, d, v);
      chk("ramp_bin7", d, 1);
      rd(16, d, v);
      chk("ramp_bin16", d, 0);
      chk("ramp_pc_sum", pc_sum, 120);
      chk("ramp_stuck", stuck, 16'h8000);

      run(3, 1, lat);
      bin_total(tot);
      chk("ign_total", tot, 16);
      rd(20, d, v);
      chk("oob_data", d, 0);
      chk("oob_valid", v, 1);
      @(posedge sclk);
      #1 chk("oob_valid_drop", rd_valid, 0);

      start = 1;
      @(posedge sclk);
      #1 start = 0;
      for (int n = 1; n <= 9; n++) begin
         dac = 16'($urandom);
         @(posedge sclk);
         #1;
      end
      rst_n = 0;
      @(posedge sclk);
      #1 chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      rst_n = 1;
      repeat (25) @(posedge sclk);
      #1 chk("mid_rst_idle", busy, 0);
      bin_total(tot);
      chk("mid_rst_total", tot, 0);
      run(3, 0, lat);
      bin_total(tot);
      chk("post_rst_total", tot, 16);

      for (int r = 0; r < 10; r++) begin
         run(3, r[0], lat);
         if (r % 3 != 2) begin
            bin_total(tot);
            chk("rand_total", tot, 16);
         end
         repeat ($urandom_range(0, 3)) @(posedge sclk);
         #1;
      end
      repeat (3) @(posedge sclk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
